// File: rtl/nr_reciprocal_param.sv
// nr_reciprocal_param: start/ready fixed-point reciprocal coprocessor.
// Normalises the unsigned divisor into [0.5,1), seeds with a linear
// approximation and refines with Newton-Raphson steps y <- y*(2 - d*y)
// until the estimate stops changing or the iteration cap is reached.
// One shared (FRAC_W+2)x(FRAC_W+2) multiplier serves the seed and both
// halves of every iteration.
module nr_reciprocal_param #(
    parameter int IN_W     = 16,
    parameter int FRAC_W   = 19,
    parameter int INT_W    = 5,
    parameter int MAX_ITER = 8,
    localparam int CNT_W   = $clog2(MAX_ITER + 1),
    localparam int OUT_W   = INT_W + FRAC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  input0,
    output logic [OUT_W-1:0] output0,
    output logic             ready,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] iter_cnt
);

    localparam int Y_W = FRAC_W + 2;          // Q2.F working width
    localparam int P_W = 2 * Y_W;             // full product width
    localparam int S_W = $clog2(IN_W + 1);    // holds 1..IN_W

    // Seed constants round(32/17 * 2^F) and round(48/17 * 2^F)
    localparam logic [63:0]    SEED_A_L = ((64'd32 << FRAC_W) + 64'd8) / 64'd17;
    localparam logic [63:0]    SEED_B_L = ((64'd48 << FRAC_W) + 64'd8) / 64'd17;
    localparam logic [Y_W-1:0] SEED_A   = SEED_A_L[Y_W-1:0];
    localparam logic [Y_W-1:0] SEED_B   = SEED_B_L[Y_W-1:0];
    localparam logic [Y_W-1:0] TWO_Q    = {2'b10, {FRAC_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NORM  = 3'd1,
        SEED  = 3'd2,
        MUL1  = 3'd3,
        MUL2  = 3'd4,
        CHECK = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t           state_r;
    logic [IN_W-1:0]  x_r;
    logic [S_W-1:0]   s_r;
    logic [Y_W-1:0]   d_r;
    logic [Y_W-1:0]   y_r;
    logic [Y_W-1:0]   t_r;
    logic [Y_W-1:0]   y_new_r;
    logic [CNT_W-1:0] cnt_r;
    logic             zero_r;

    logic [S_W-1:0]   msb_s;
    logic [Y_W-1:0]   norm_d_s;
    logic [Y_W-1:0]   two_minus_t_s;
    logic [Y_W-1:0]   mul_a_s;
    logic [Y_W-1:0]   mul_b_s;
    logic [P_W-1:0]   prod_s;
    logic [Y_W-1:0]   prod_mid_s;

    // Position of the most significant set bit plus one (0 when v is zero)
    function automatic logic [S_W-1:0] msb_plus1(input logic [IN_W-1:0] v);
        logic [S_W-1:0] r;
        r = '0;
        for (int i = 0; i < IN_W; i++) begin
            r = v[i] ? S_W'(i + 1) : r;
        end
        return r;
    endfunction

    // Normalisation shift and Newton correction factor
    always_comb begin
        msb_s         = msb_plus1(x_r);
        norm_d_s      = Y_W'(x_r) << (FRAC_W - int'(msb_s));
        two_minus_t_s = TWO_Q - t_r;
    end

    // Shared multiplier: operand selection follows the active step
    always_comb begin
        mul_a_s = '0;
        mul_b_s = '0;
        case (state_r)
            SEED: begin
                mul_a_s = SEED_A;
                mul_b_s = d_r;
            end
            MUL1: begin
                mul_a_s = d_r;
                mul_b_s = y_r;
            end
            MUL2: begin
                mul_a_s = y_r;
                mul_b_s = two_minus_t_s;
            end
            default: begin
                mul_a_s = '0;
                mul_b_s = '0;
            end
        endcase
        prod_s     = P_W'(mul_a_s) * P_W'(mul_b_s);
        prod_mid_s = Y_W'(prod_s >> FRAC_W);
    end

    // Control FSM with registered datapath and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            x_r      <= '0;
            s_r      <= '0;
            d_r      <= '0;
            y_r      <= '0;
            t_r      <= '0;
            y_new_r  <= '0;
            cnt_r    <= '0;
            zero_r   <= 1'b0;
            output0  <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            iter_cnt <= '0;
        end else begin
            ready <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (input0 == '0) begin
                            zero_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            x_r     <= input0;
                            zero_r  <= 1'b0;
                            state_r <= NORM;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                NORM: begin
                    s_r     <= msb_s;
                    d_r     <= norm_d_s;
                    state_r <= SEED;
                end
                SEED: begin
                    y_r     <= SEED_B - prod_mid_s;
                    cnt_r   <= '0;
                    state_r <= MUL1;
                end
                MUL1: begin
                    t_r     <= prod_mid_s;
                    state_r <= MUL2;
                end
                MUL2: begin
                    y_new_r <= prod_mid_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    state_r <= CHECK;
                end
                CHECK: begin
                    y_r <= y_new_r;
                    if ((y_new_r == y_r) || (cnt_r == CNT_W'(MAX_ITER))) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= MUL1;
                    end
                end
                DONE: begin
                    if (zero_r) begin
                        output0  <= '1;
                        err      <= 1'b1;
                        iter_cnt <= '0;
                    end else begin
                        output0  <= OUT_W'(y_r >> s_r);
                        err      <= 1'b0;
                        iter_cnt <= cnt_r;
                    end
                    zero_r  <= 1'b0;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nr_reciprocal_param.sv
// Self-checking bench for nr_reciprocal_param (defaults IN_W=16, F=19,
// INT_W=5, MAX_ITER=8). The reference is the exact reciprocal
// floor(2^19/x) with a small tolerance for the iterative rounding.
module tb_nr_reciprocal_param;

    localparam int IN_W     = 16;
    localparam int FRAC_W   = 19;
    localparam int INT_W    = 5;
    localparam int MAX_ITER = 8;
    localparam int CNT_W    = $clog2(MAX_ITER + 1);
    localparam int OUT_W    = INT_W + FRAC_W;

    logic             clk;
    logic             rst;
    logic             start;
    logic [IN_W-1:0]  input0;
    logic [OUT_W-1:0] output0;
    logic             ready;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] iter_cnt;

    int total;
    int bad;

    nr_reciprocal_param #(
        .IN_W(IN_W), .FRAC_W(FRAC_W), .INT_W(INT_W), .MAX_ITER(MAX_ITER)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .input0(input0),
        .output0(output0), .ready(ready), .busy(busy), .err(err),
        .iter_cnt(iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge just after the accepting edge. Counts edges until
    // ready is seen; optionally pokes start with another operand mid-flight.
    task automatic wait_ready(input int poke_at, input logic [IN_W-1:0] poke_x,
                              output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == poke_at) begin
                start  = 1'b1;
                input0 = poke_x;
            end else if (lat == poke_at + 1) begin
                start = 1'b0;
            end
            if (ready) seen = 1'b1;
        end
    endtask

    // Compare one completed result against the exact reciprocal
    task automatic check_result(input string tag, input int x, input logic [OUT_W-1:0] out,
                                input logic e, input logic [CNT_W-1:0] it, input int lat, input bit seen);
        int  expv;
        int  tol;
        bit  in_tol;
        check_eq({tag, "_ready_seen"}, 32'(seen), 32'd1);
        if (x == 0) begin
            check_eq({tag, "_out"}, 32'(out), 32'h00FF_FFFF);
            check_eq({tag, "_err"}, 32'(e), 32'd1);
            check_eq({tag, "_iter"}, 32'(it), 32'd0);
            check_eq({tag, "_lat"}, 32'(lat), 32'd1);
        end else begin
            expv = (1 << FRAC_W) / x;
            tol = ((x & (x - 1)) == 0) ? 0 : ((x >= 32768) ? 1 : 2);
            in_tol = (int'(out) >= expv - tol) && (int'(out) <= expv + tol);
            if (!in_tol)
                $display("note %s: x=%0d out=0x%0h ref=0x%0h tol=%0d", tag, x, out, expv, tol);
            check_eq({tag, "_within_tol"}, 32'(in_tol), 32'd1);
            check_eq({tag, "_err"}, 32'(e), 32'd0);
            check_eq({tag, "_iter_range"}, 32'((it >= 1) && (it <= MAX_ITER)), 32'd1);
            check_eq({tag, "_lat"}, 32'(lat), 32'(3 + 3 * int'(it)));
        end
    endtask

    // Full single operation from IDLE; called at a negedge
    task automatic do_op(input string tag, input logic [IN_W-1:0] x, input int poke_at,
                         input logic [IN_W-1:0] poke_x);
        int lat;
        bit seen;
        input0 = x;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        wait_ready(poke_at, poke_x, lat, seen);
        check_result(tag, int'(x), output0, err, iter_cnt, lat, seen);
        @(negedge clk);
        check_eq({tag, "_ready_1cyc"}, 32'(ready), 32'd0);
        check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        bit seen;
        int cnt_ready;
        logic [IN_W-1:0] rx;
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        start  = 1'b0;
        input0 = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_out", 32'(output0), 32'd0);
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_iter", 32'(iter_cnt), 32'd0);
        rst = 1'b0;

        // x=1 gives exactly 1.0
        do_op("x1", 16'd1, -10, 16'd0);
        check_eq("x1_exact", 32'(output0), 32'h0008_0000);

        // back-to-back x=2 then x=4 with start held high
        input0 = 16'd2;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        input0 = 16'd4;
        wait_ready(-10, 16'd0, lat, seen);
        check_result("b2b_x2", 2, output0, err, iter_cnt, lat, seen);
        check_eq("b2b_x2_exact", 32'(output0), 32'h0004_0000);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_eq("b2b_ready_low", 32'(ready), 32'd0);
        check_eq("b2b_accept_busy", 32'(busy), 32'd1);
        wait_ready(-10, 16'd0, lat, seen);
        check_result("b2b_x4", 4, output0, err, iter_cnt, lat, seen);
        check_eq("b2b_x4_exact", 32'(output0), 32'h0002_0000);
        @(negedge clk);

        do_op("x3", 16'd3, -10, 16'd0);
        do_op("x65535", 16'd65535, -10, 16'd0);

        // divide by zero, then a normal operand clears err
        do_op("x0", 16'd0, -10, 16'd0);
        do_op("x5", 16'd5, -10, 16'd0);

        // start pulsed mid-operation with another operand is ignored
        do_op("midop_x3", 16'd3, 2, 16'd7);

        // asynchronous reset during MUL2 aborts without a ready pulse
        input0 = 16'd100;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out", 32'(output0), 32'd0);
        check_eq("arst_ready", 32'(ready), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_err", 32'(err), 32'd0);
        check_eq("arst_iter", 32'(iter_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt_ready = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) cnt_ready++;
        end
        check_eq("arst_no_ready", 32'(cnt_ready), 32'd0);
        do_op("x8", 16'd8, -10, 16'd0);
        check_eq("x8_exact", 32'(output0), 32'h0001_0000);

        // randomized operands across all magnitudes
        for (int n = 0; n < 24; n++) begin
            rx = 16'($urandom_range(1, 65535) >> $urandom_range(0, 15));
            if (rx == '0) rx = 16'd1;
            do_op("rand", rx, -10, 16'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nr_reciprocal_param.md
# nr_reciprocal_param

Parametrised fixed-point reciprocal unit: computes output0 ≈ 1/input0 for an unsigned integer input using seeded Newton-Raphson refinement. It is the generalised successor of the fixed Q5.19 reciprocal block. It is generic in input width, fraction width, integer width and iteration cap, and has an internal multiplier, convergence/iteration reporting and divide-by-zero detection. It sits behind the arithmetic exercise datapath as a start/ready coprocessor.

## Interface
- IN_W, 16: width of unsigned integer operand; constraint 1 ≤ IN_W ≤ FRAC_W.
- FRAC_W, 19: fraction bits of result and internal values.
- INT_W, 5: integer bits of result; constraint INT_W ≥ 1.
- MAX_ITER, 8: maximum Newton iterations; constraint ≥ 1.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- input0  in  IN_W  unsigned divisor x; captured on the accepting edge.
- output0  out  INT_W+FRAC_W  result, unsigned Q(INT_W).(FRAC_W); held until next completion.
- ready  out  1  one-cycle completion pulse; output0/err/iter_cnt valid while high and after.
- busy  out  1  high in every state except IDLE.
- err  out  1  set with ready when x = 0.
- iter_cnt  out  clog2(MAX_ITER+1)  iterations executed for the last result.

## Operation
- States: IDLE, NORM, SEED, MUL1, MUL2, CHECK, DONE.
- IDLE: start=1 and x≠0 → capture x, go to NORM; start=1 and x=0 → go to DONE with zero flag; start=0 → stay.
- NORM: s = index of MSB of x plus 1 (1..IN_W); d = x·2^-s in [0.5,1) as unsigned Q1.F (x << (FRAC_W−s)). Go to SEED.
- SEED: y = B − floor(A·d), with A = round(32/17·2^F) and B = round(48/17·2^F), computed from FRAC_W at elaboration. y is Q2.F. Clear iteration counter. Go to MUL1.
- MUL1: t ← floor(d·y), Q2.F. Go to MUL2.
- MUL2: y_new ← floor(y·(2−t)), Q2.F. Increment counter. Go to CHECK.
- CHECK: if y_new == y or counter == MAX_ITER → DONE; else y ← y_new, go to MUL1. If stopping, y ← y_new.
- DONE: output0 ← zero-extend(y >> s), floor; err ← 0; iter_cnt ← counter; ready ← 1. For the zero case: output0 ← all ones, err ← 1, iter_cnt ← 0. Go to IDLE.
- Multiplier: one internal (FRAC_W+2)×(FRAC_W+2) unsigned product, registered in MUL1/MUL2 and shared. Bits [2F+1:F] are taken. No external multiplier handshake.
- start asserted outside IDLE is ignored and not queued.
- start held high in IDLE on the cycle ready pulses starts a new operation, back-to-back.

## Timing
- Edge 0 = edge where IDLE accepts start.
- Nonzero x with k iterations (1 ≤ k ≤ MAX_ITER): DONE is entered at edge 2+3k. ready is high from edge 3+3k to edge 4+3k, so latency is 3+3k cycles. The worst case is 3+3·MAX_ITER.
- x = 0: ready high from edge 1 for one cycle.
- busy rises at edge 0 and falls on the edge that ready rises (DONE→IDLE).
- Reset values, asserted asynchronously at any time including mid-operation:
  - state = IDLE.
  - output0 = 0, ready = 0, busy = 0, err = 0, iter_cnt = 0.
  - All internal registers = 0.
  - No ready pulse for the aborted operation.
- After rst deasserts, the first start is accepted on the first rising edge where rst is low.
- output0, err and iter_cnt change only on the ready edge.

## Test plan
Defaults FRAC_W=19, INT_W=5, MAX_ITER=8.
- x=1 → output0=0x080000 (1.0), err=0, ready exactly one cycle, latency 3+3·iter_cnt.
- x=2, then x=4 back-to-back, start held high → 0x040000, then 0x020000. The second operation is accepted on the cycle the first ready pulses.
- x=3 → output0 within ±2 LSB of 0x02AAAA; x=65535 → within ±1 of 0x000008; iter_cnt ≤ 8 for both.
- x=0 → ready at edge 1, err=1, output0=0xFFFFFF, iter_cnt=0. The next x=5 clears err; output0 within ±2 of 0x019999.
- start pulsed again mid-operation with a different input0 → ignored; result matches the first operand only.
- rst asserted during MUL2, between clock edges → all outputs 0 immediately; no ready. A following start with x=8 → 0x010000.
